mcu_core_p: RTL

//  Parametrised multi-cycle accumulator MCU core; successor to the fixed 16-bit ROM/ALU/controller top.

---
 rtl/mcu_core_p_if.sv | 13 +
 rtl/mcu_core_p.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mcu_core_p_if.sv
// ROM fetch bus between the accumulator core (master) and its synchronous program ROM (slave).
// rom_data is valid the cycle after the ROM samples rom_cs & rom_re.
interface mcu_core_p_if #(
    parameter int PW = 8
) ();
    logic [PW-1:0] rom_addr;
    logic          rom_cs;
    logic          rom_re;
    logic [15:0]   rom_data;

    modport master (output rom_addr, output rom_cs, output rom_re, input rom_data);
    modport slave  (input rom_addr, input rom_cs, input rom_re, output rom_data);
endinterface

// File: rtl/mcu_core_p.sv
// Multi-cycle accumulator MCU core: FETCH -> DECODE -> EXEC [-> MEMOP] with data RAM,
// carry flag, wide MUL product (acc_h), port I/O, conditional jumps and a sticky HALT state.
module mcu_core_p #(
    parameter int DW  = 16,
    parameter int PW  = 8,
    parameter int RAW = 4
) (
    input  logic          clk,
    input  logic          rst,
    mcu_core_p_if.master  rom,
    input  logic [DW-1:0] port_in,
    output logic [DW-1:0] port_out,
    output logic [DW-1:0] acc,
    output logic [DW-1:0] acc_h,
    output logic          carry,
    output logic          halted
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEMOP  = 3'd3,
        HALT   = 3'd4
    } coreStateT;

    localparam logic [3:0] OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3, OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7, OP_XOR = 4'h8;
    localparam logic [3:0] OP_MUL = 4'h9, OP_IN  = 4'hA, OP_OUT = 4'hB, OP_JMP = 4'hC;
    localparam logic [3:0] OP_JZ  = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF;

    coreStateT       stateR, nextStateS;
    logic [PW-1:0]   pcR;
    logic [15:0]     irR;
    logic [DW-1:0]   accR, accHR, portOutR, ramRdR;
    logic            carryR, haltedR, romCsR;
    logic [DW-1:0]   ramR [0:(1 << RAW)-1];

    logic [3:0]      opS;
    logic [DW-1:0]   immS;
    logic [PW-1:0]   jmpTargetS;
    logic [RAW-1:0]  ramAddrS;
    logic            needRamS, ramWeS;
    logic [DW:0]     sumS, diffS;
    logic [2*DW-1:0] prodS;

    assign opS        = irR[15:12];
    assign immS       = DW'(irR[11:0]);
    assign jmpTargetS = irR[PW-1:0];
    assign ramAddrS   = irR[RAW-1:0];
    assign needRamS   = (opS == OP_LD)  || (opS == OP_ADD) || (opS == OP_SUB) || (opS == OP_AND) ||
                        (opS == OP_OR)  || (opS == OP_XOR) || (opS == OP_MUL);
    // rst term keeps an ST from landing on the edge where reset is asserted
    assign ramWeS     = (stateR == EXEC) && (opS == OP_ST) && rst;
    assign sumS       = {1'b0, accR} + {1'b0, ramRdR};
    assign diffS      = {1'b0, accR} - {1'b0, ramRdR};
    assign prodS      = {{DW{1'b0}}, accR} * {{DW{1'b0}}, ramRdR};

    assign rom.rom_addr = pcR;
    assign rom.rom_cs   = romCsR;
    assign rom.rom_re   = romCsR;
    assign port_out     = portOutR;
    assign acc          = accR;
    assign acc_h        = accHR;
    assign carry        = carryR;
    assign halted       = haltedR;

    // State register and registered ROM strobe (asserted for the cycle spent in FETCH).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateR <= FETCH;
            romCsR <= 1'b0;
        end else begin
            stateR <= nextStateS;
            romCsR <= (nextStateS == FETCH);
        end
    end

    // Next-state decode; FETCH waits until the strobe is actually on the bus.
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            FETCH: begin
                if (romCsR) nextStateS = DECODE;
                else        nextStateS = FETCH;
            end
            DECODE: nextStateS = EXEC;
            EXEC: begin
                if (opS == OP_HLT) nextStateS = HALT;
                else if (needRamS) nextStateS = MEMOP;
                else               nextStateS = FETCH;
            end
            MEMOP:   nextStateS = FETCH;
            HALT:    nextStateS = HALT;
            default: nextStateS = FETCH;
        endcase
    end

    // Architectural state: instruction latch, pc, accumulator, flags and ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcR      <= {PW{1'b0}};
            irR      <= 16'h0000;
            accR     <= {DW{1'b0}};
            accHR    <= {DW{1'b0}};
            portOutR <= {DW{1'b0}};
            carryR   <= 1'b0;
            haltedR  <= 1'b0;
        end else if (stateR == DECODE) begin
            irR <= rom.rom_data;
            pcR <= pcR + {{(PW-1){1'b0}}, 1'b1};
        end else if (stateR == EXEC) begin
            case (opS)
                OP_LDI: accR     <= immS;
                OP_IN:  accR     <= port_in;
                OP_OUT: portOutR <= accR;
                OP_JMP: pcR      <= jmpTargetS;
                OP_JZ:  if (accR == {DW{1'b0}}) pcR <= jmpTargetS;
                OP_JC:  if (carryR) pcR <= jmpTargetS;
                OP_HLT: haltedR  <= 1'b1;
                default: ;
            endcase
        end else if (stateR == MEMOP) begin
            case (opS)
                OP_LD:  accR <= ramRdR;
                OP_ADD: {carryR, accR} <= sumS;
                OP_SUB: {carryR, accR} <= diffS;
                OP_AND: accR <= accR & ramRdR;
                OP_OR:  accR <= accR | ramRdR;
                OP_XOR: accR <= accR ^ ramRdR;
                OP_MUL: begin
                    {accHR, accR} <= prodS;
                    carryR        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Data RAM: synchronous read launched in EXEC, ST write in EXEC; contents not reset.
    always_ff @(posedge clk) begin
        if (ramWeS) ramR[ramAddrS] <= accR;
        if (stateR == EXEC) ramRdR <= ramR[ramAddrS];
    end
endmodule
